mem_access_stage: RTL and testbench
===================================

Name: mem_access_stage

Overview:
Memory stage of the SPARC pipeline. It consumes the EX/MEM pipeline register outputs and performs SPARC v8 integer loads and stores (LDSB/LDSH/LDUB/LDUH/LD/LDD/STB/STH/ST/STD) over a 64-bit big-endian request/ack data-memory bus. It produces the MEM/WB register contents and drives mem_ready, which stalls the EX/MEM register and every stage upstream of it.

Parameters:
ADDR_WIDTH, 64, width of mem_addr; taken from the low bits of ex_alures.

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
ex_regD  in  5  destination register
ex_alures  in  64  ALU result; effective address for memory ops
ex_op  in  2  format op field; 2'b11 = memory op
ex_op3  in  6  op3 field
ex_valD  in  64  store data
ex_regWrite, ex_regWriteDouble, ex_icc_write, ex_Y_write  in  1 each  writeback enables
ex_icc  in  4  condition codes
ex_Y  in  32  Y register value
mem_ready  out  1  1 = instruction in EX/MEM retires this cycle; EX/MEM may advance
mem_req  out  1  bus request
mem_we  out  1  1 = store
mem_addr  out  ADDR_WIDTH  doubleword-aligned address (low 3 bits zero)
mem_wstrb  out  8  byte strobes; bit 7-k = byte offset k
mem_wdata  out  64  store data; byte offset 0 in bits [63:56]
mem_ack  in  1  bus completion; sampled only while mem_req=1
mem_rdata  in  64  load data, valid with mem_ack
wb_regD, wb_result, wb_regWrite, wb_regWriteDouble, wb_icc, wb_icc_write, wb_Y, wb_Y_write  out  5/64/1/1/4/1/32/1  registered MEM/WB outputs
mem_trap  out  1  registered one-cycle trap pulse
mem_trap_cause  out  2  01 = misaligned, 10 = unsupported op3

Behaviour:
- Interface: clock clk; reset reset, synchronous, active-high.
- Reset: state=IDLE. All wb_* outputs, mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata, mem_trap and mem_trap_cause are 0.
- Decode: a memory op is ex_op==2'b11.
  - Supported op3 values: 00 LD, 01 LDUB, 02 LDUH, 03 LDD, 04 ST, 05 STB, 06 STH, 07 STD, 09 LDSB, 0A LDSH.
  - Any other op3 with op==3 is unsupported.
- Alignment: half requires a[0]=0; word requires a[1:0]=0; double requires a[2:0]=0. Bytes are always aligned.
- IDLE, non-memory op: mem_ready=1 combinationally. On the edge, wb_* take the ex_* values, with wb_result=ex_alures.
- IDLE, misaligned or unsupported memory op:
  - No bus request; mem_ready=1.
  - On the edge, the wb_* enables (regWrite, regWriteDouble, icc_write, Y_write) are written 0.
  - mem_trap=1 with the cause for one cycle.
- IDLE, valid memory op:
  - mem_ready=0.
  - On the edge, register mem_req=1, mem_we, mem_addr={a[ADDR_WIDTH-1:3],3'b0}, mem_wstrb and mem_wdata, and go to WAIT.
  - The wb_* enables are written 0 (bubble).
- WAIT: mem_req and the bus fields are held stable.
  - No ack: mem_ready=0, and the wb_* enables are written 0 each cycle.
  - Ack: mem_ready=1. On that edge, drop mem_req/mem_we/mem_wstrb to 0, write wb_* from ex_*, and go to IDLE.
  - Minimum latency is 2 cycles per memory op (ack in the first WAIT cycle).
- Load data, offset k=a[2:0]:
  - Byte = rdata[63-8k -: 8]. Half = rdata[63-8k -: 16]. Word = rdata[63-8k -: 32].
  - LDSB/LDSH sign-extend to 64 bits; LDUB/LDUH/LD zero-extend.
  - LDD returns rdata unmodified (bits [63:32] go to the even register); wb_regWriteDouble=ex_regWriteDouble.
- Stores:
  - wdata is ex_valD[7:0] replicated ×8 for STB, [15:0] ×4 for STH, [31:0] ×2 for ST, and [63:0] for STD.
  - wstrb covers exactly the accessed bytes.
  - wb_regWrite is forced 0; wb_result=ex_alures.
- ex_icc/ex_Y and their write enables pass through unchanged for retiring instructions.
- A mem_ack arriving in IDLE (mem_req=0) is ignored.
- Reset in WAIT: the next cycle is IDLE with mem_req=0. A late ack is ignored; the bus must tolerate abandoned requests.
- ex_* inputs are held stable by the EX/MEM register whenever mem_ready=0.

Test Plan:
1. LDSB, a=0x1004, rdata=0x0011_2233_8455_6677, ack in first WAIT cycle -> mem_addr=0x1000, mem_we=0; mem_ready 0,1; wb_result=0xFFFF_FFFF_FFFF_FF84, wb_regWrite=1.
2. LDUH at 0x1006 -> wb_result=0x6677. LD at 0x1004 -> wb_result=0x0000_0000_8455_6677. LDD at 0x1000 -> wb_result=rdata, wb_regWriteDouble=1.
3. STH, a=0x2002, valD=0xABCD -> mem_we=1, mem_addr=0x2000, wstrb=8'b0011_0000, wdata=0xABCD_ABCD_ABCD_ABCD, wb_regWrite=0.
4. LD at 0x1002 -> mem_req stays 0, mem_ready=1, next cycle mem_trap=1, cause=01, wb_regWrite=0. op=3, op3=0x0D -> cause=10.
5. ST with ack delayed to 4th WAIT cycle -> mem_ready=0 for 4 cycles then 1; wb enables 0 throughout the stall; exactly one retirement; no second request.
6. Reset asserted in WAIT, then ack 2 cycles later -> mem_req=0 after reset, wb_* stay 0, and the next ALU op retires normally in 1 cycle.

Source files
------------

// File: rtl/mem_access_stage.sv
// Memory access stage: SPARC v8 integer loads/stores over a 64-bit
// big-endian request/ack bus, producing the MEM/WB register and the
// mem_ready stall for EX/MEM and everything upstream.
module mem_access_stage #(
    parameter int ADDR_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [4:0]            ex_regD,
    input  logic [63:0]           ex_alures,
    input  logic [1:0]            ex_op,
    input  logic [5:0]            ex_op3,
    input  logic [63:0]           ex_valD,
    input  logic                  ex_regWrite,
    input  logic                  ex_regWriteDouble,
    input  logic                  ex_icc_write,
    input  logic                  ex_Y_write,
    input  logic [3:0]            ex_icc,
    input  logic [31:0]           ex_Y,
    output logic                  mem_ready,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [7:0]            mem_wstrb,
    output logic [63:0]           mem_wdata,
    input  logic                  mem_ack,
    input  logic [63:0]           mem_rdata,
    output logic [4:0]            wb_regD,
    output logic [63:0]           wb_result,
    output logic                  wb_regWrite,
    output logic                  wb_regWriteDouble,
    output logic [3:0]            wb_icc,
    output logic                  wb_icc_write,
    output logic [31:0]           wb_Y,
    output logic                  wb_Y_write,
    output logic                  mem_trap,
    output logic [1:0]            mem_trap_cause
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_WAIT = 1'b1;

    logic [0:0]  state;
    logic        is_mem;
    logic        supported;
    logic        is_store;
    logic        is_signed;
    logic [1:0]  size;        // 0 byte, 1 half, 2 word, 3 double
    logic        misaligned;
    logic        bad_op;
    logic        start_op;
    logic [2:0]  offset;
    logic [63:0] shifted;
    logic [63:0] load_data;
    logic [63:0] store_data;
    logic [7:0]  store_strb;
    logic [63:0] ret_result;
    logic        ret_regWrite;

    // Decode op3 into access size, direction and signedness
    always_comb begin
        supported = 1'b1;
        is_store  = 1'b0;
        is_signed = 1'b0;
        size      = 2'd0;
        case (ex_op3)
            6'h00: size = 2'd2;
            6'h01: size = 2'd0;
            6'h02: size = 2'd1;
            6'h03: size = 2'd3;
            6'h04: begin size = 2'd2; is_store = 1'b1; end
            6'h05: begin size = 2'd0; is_store = 1'b1; end
            6'h06: begin size = 2'd1; is_store = 1'b1; end
            6'h07: begin size = 2'd3; is_store = 1'b1; end
            6'h09: begin size = 2'd0; is_signed = 1'b1; end
            6'h0A: begin size = 2'd1; is_signed = 1'b1; end
            default: supported = 1'b0;
        endcase
    end

    assign offset = ex_alures[2:0];
    assign is_mem = (ex_op == 2'b11);

    // Natural-alignment check for the decoded access size
    always_comb begin
        case (size)
            2'd1:    misaligned = offset[0];
            2'd2:    misaligned = |offset[1:0];
            2'd3:    misaligned = |offset;
            default: misaligned = 1'b0;
        endcase
    end

    assign bad_op   = is_mem && (!supported || misaligned);
    assign start_op = is_mem && supported && !misaligned;

    // Stall while a valid memory op is being issued or awaits its ack
    always_comb begin
        if (state == S_IDLE) mem_ready = !start_op;
        else                 mem_ready = mem_ack;
    end

    // Left-justify the addressed byte so every width extracts from the top
    assign shifted = mem_rdata << {offset, 3'b000};

    // Load data extraction with sign/zero extension
    always_comb begin
        case (size)
            2'd0:    load_data = is_signed ? {{56{shifted[63]}}, shifted[63:56]}
                                           : {56'd0, shifted[63:56]};
            2'd1:    load_data = is_signed ? {{48{shifted[63]}}, shifted[63:48]}
                                           : {48'd0, shifted[63:48]};
            2'd2:    load_data = {32'd0, shifted[63:32]};
            default: load_data = mem_rdata;
        endcase
    end

    // Store data replication and byte strobes
    always_comb begin
        case (size)
            2'd0: begin
                store_data = {8{ex_valD[7:0]}};
                store_strb = 8'h80 >> offset;
            end
            2'd1: begin
                store_data = {4{ex_valD[15:0]}};
                store_strb = 8'hC0 >> offset;
            end
            2'd2: begin
                store_data = {2{ex_valD[31:0]}};
                store_strb = 8'hF0 >> offset;
            end
            default: begin
                store_data = ex_valD;
                store_strb = 8'hFF;
            end
        endcase
    end

    assign ret_result   = (is_mem && !is_store) ? load_data : ex_alures;
    assign ret_regWrite = ex_regWrite && !(is_mem && is_store);

    // FSM, bus request registers and MEM/WB register
    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= S_IDLE;
            mem_req           <= 1'b0;
            mem_we            <= 1'b0;
            mem_addr          <= '0;
            mem_wstrb         <= '0;
            mem_wdata         <= '0;
            wb_regD           <= '0;
            wb_result         <= '0;
            wb_regWrite       <= 1'b0;
            wb_regWriteDouble <= 1'b0;
            wb_icc            <= '0;
            wb_icc_write      <= 1'b0;
            wb_Y              <= '0;
            wb_Y_write        <= 1'b0;
            mem_trap          <= 1'b0;
            mem_trap_cause    <= '0;
        end else begin
            mem_trap       <= 1'b0;
            mem_trap_cause <= '0;
            // Default is a bubble; retirement overrides the enables below
            wb_regWrite       <= 1'b0;
            wb_regWriteDouble <= 1'b0;
            wb_icc_write      <= 1'b0;
            wb_Y_write        <= 1'b0;
            if ((state == S_IDLE && !is_mem) || (state == S_WAIT && mem_ack)) begin
                wb_regD           <= ex_regD;
                wb_result         <= ret_result;
                wb_regWrite       <= ret_regWrite;
                wb_regWriteDouble <= ex_regWriteDouble;
                wb_icc            <= ex_icc;
                wb_icc_write      <= ex_icc_write;
                wb_Y              <= ex_Y;
                wb_Y_write        <= ex_Y_write;
            end
            case (state)
                S_IDLE: begin
                    if (bad_op) begin
                        mem_trap       <= 1'b1;
                        mem_trap_cause <= supported ? 2'b01 : 2'b10;
                    end else if (start_op) begin
                        mem_req   <= 1'b1;
                        mem_we    <= is_store;
                        mem_addr  <= {ex_alures[ADDR_WIDTH-1:3], 3'b000};
                        mem_wstrb <= store_strb;
                        mem_wdata <= store_data;
                        state     <= S_WAIT;
                    end
                end
                default: begin
                    if (mem_ack) begin
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_wstrb <= '0;
                        state     <= S_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Randomized self-checking bench for mem_access_stage against a
// byte-array reference model of SPARC v8 load/store semantics.
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  ex_regD;
    logic [63:0] ex_alures;
    logic [1:0]  ex_op;
    logic [5:0]  ex_op3;
    logic [63:0] ex_valD;
    logic        ex_regWrite, ex_regWriteDouble, ex_icc_write, ex_Y_write;
    logic [3:0]  ex_icc;
    logic [31:0] ex_Y;
    logic        mem_ready, mem_req, mem_we;
    logic [63:0] mem_addr;
    logic [7:0]  mem_wstrb;
    logic [63:0] mem_wdata;
    logic        mem_ack;
    logic [63:0] mem_rdata;
    logic [4:0]  wb_regD;
    logic [63:0] wb_result;
    logic        wb_regWrite, wb_regWriteDouble, wb_icc_write, wb_Y_write;
    logic [3:0]  wb_icc;
    logic [31:0] wb_Y;
    logic        mem_trap;
    logic [1:0]  mem_trap_cause;

    int checks = 0;
    int errors = 0;

    mem_access_stage #(.ADDR_WIDTH(64)) dut (
        .clk(clk), .reset(reset),
        .ex_regD(ex_regD), .ex_alures(ex_alures), .ex_op(ex_op), .ex_op3(ex_op3),
        .ex_valD(ex_valD), .ex_regWrite(ex_regWrite),
        .ex_regWriteDouble(ex_regWriteDouble), .ex_icc_write(ex_icc_write),
        .ex_Y_write(ex_Y_write), .ex_icc(ex_icc), .ex_Y(ex_Y),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .wb_regD(wb_regD), .wb_result(wb_result), .wb_regWrite(wb_regWrite),
        .wb_regWriteDouble(wb_regWriteDouble), .wb_icc(wb_icc),
        .wb_icc_write(wb_icc_write), .wb_Y(wb_Y), .wb_Y_write(wb_Y_write),
        .mem_trap(mem_trap), .mem_trap_cause(mem_trap_cause)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "simulation time limit");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Access width in bytes (0 = unsupported), direction and signedness
    task automatic op_info(input logic [5:0] op3, output int n, output bit st, output bit sg);
        n = 0; st = 0; sg = 0;
        case (op3)
            6'h00: n = 4;
            6'h01: n = 1;
            6'h02: n = 2;
            6'h03: n = 8;
            6'h04: begin n = 4; st = 1; end
            6'h05: begin n = 1; st = 1; end
            6'h06: begin n = 2; st = 1; end
            6'h07: begin n = 8; st = 1; end
            6'h09: begin n = 1; sg = 1; end
            6'h0A: begin n = 2; sg = 1; end
            default: n = 0;
        endcase
    endtask

    function automatic logic [63:0] ref_load(input int n, input bit sg, input int k, input logic [63:0] rd);
        logic [7:0]  b [8];
        logic [63:0] v = 0;
        for (int i = 0; i < 8; i++) b[i] = 8'(rd >> (8 * (7 - i)));
        for (int i = 0; i < n; i++) v = (v << 8) | 64'(b[k + i]);
        if (sg && n < 8 && v[8 * n - 1]) v = v | ~((64'd1 << (8 * n)) - 64'd1);
        return v;
    endfunction

    function automatic logic [7:0] ref_strb(input int n, input int k);
        logic [7:0] s = 0;
        for (int i = k; i < k + n; i++) s[7 - i] = 1'b1;
        return s;
    endfunction

    function automatic logic [63:0] ref_wdata(input int n, input logic [63:0] vd);
        logic [63:0] w = 0;
        for (int i = 0; i < 8; i++) w = (w << 8) | 64'(8'(vd >> (8 * (n - 1 - (i % n)))));
        return w;
    endfunction

    task automatic run_op(input logic [1:0] op, input logic [5:0] op3, input logic [63:0] a,
                          input logic [63:0] vd, input logic [63:0] rd, input int delay,
                          input bit idle_ack);
        int n; bit st, sg; int k;
        logic rw, rwd, iw, yw;
        logic [4:0] rg; logic [3:0] icc; logic [31:0] y;
        logic [63:0] exp_res;
        op_info(op3, n, st, sg);
        k = int'(a[2:0]);
        rg = 5'($urandom); rw = 1'($urandom); rwd = 1'($urandom);
        iw = 1'($urandom); yw = 1'($urandom); icc = 4'($urandom); y = $urandom;
        ex_op = op; ex_op3 = op3; ex_alures = a; ex_valD = vd; ex_regD = rg;
        ex_regWrite = rw; ex_regWriteDouble = rwd; ex_icc_write = iw; ex_Y_write = yw;
        ex_icc = icc; ex_Y = y;
        mem_ack = idle_ack; mem_rdata = {$urandom, $urandom};
        #1;
        if (op != 2'b11) begin
            check("alu_ready", 64'(mem_ready), 1);
            step();
            check("alu_result", wb_result, a);
            check("alu_regD", 64'(wb_regD), 64'(rg));
            check("alu_en", {wb_regWrite, wb_regWriteDouble, wb_icc_write, wb_Y_write},
                  {rw, rwd, iw, yw});
            check("alu_iccY", {wb_icc, wb_Y}, {icc, y});
            check("alu_req", {mem_req, mem_trap}, 0);
        end else if (n == 0 || (a % 64'(n)) != 0) begin
            check("trap_ready", 64'(mem_ready), 1);
            step();
            check("trap_req", 64'(mem_req), 0);
            check("trap_pulse", 64'(mem_trap), 1);
            check("trap_cause", 64'(mem_trap_cause), (n == 0) ? 2 : 1);
            check("trap_en", {wb_regWrite, wb_regWriteDouble, wb_icc_write, wb_Y_write}, 0);
        end else begin
            check("mem_ready_issue", 64'(mem_ready), 0);
            step();
            mem_ack = 0;
            check("mem_trap_clear", 64'(mem_trap), 0);
            for (int d = 0; d <= delay; d++) begin
                check("wait_req", {mem_req, mem_we}, {1'b1, st});
                check("wait_addr", mem_addr, a & ~64'd7);
                check("wait_en", {wb_regWrite, wb_regWriteDouble, wb_icc_write, wb_Y_write}, 0);
                if (st) begin
                    check("wait_strb", 64'(mem_wstrb), 64'(ref_strb(n, k)));
                    check("wait_wdata", mem_wdata, ref_wdata(n, vd));
                end
                if (d < delay) begin
                    #1 check("wait_ready", 64'(mem_ready), 0);
                    step();
                end
            end
            mem_ack = 1; mem_rdata = rd;
            #1 check("ack_ready", 64'(mem_ready), 1);
            step();
            mem_ack = 0;
            exp_res = st ? a : ref_load(n, sg, k, rd);
            check("ret_req", {mem_req, mem_we, mem_wstrb}, 0);
            check("ret_result", wb_result, exp_res);
            check("ret_en", {wb_regWrite, wb_regWriteDouble, wb_icc_write, wb_Y_write},
                  {rw & ~st, rwd, iw, yw});
            check("ret_misc", {wb_regD, wb_icc, wb_Y}, {rg, icc, y});
        end
    endtask

    logic [5:0] good_op3 [10] = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07, 6'h09, 6'h0A};

    initial begin
        reset = 1; mem_ack = 0; mem_rdata = 0;
        ex_op = 0; ex_op3 = 0; ex_alures = 0; ex_valD = 0; ex_regD = 0;
        ex_regWrite = 0; ex_regWriteDouble = 0; ex_icc_write = 0; ex_Y_write = 0;
        ex_icc = 0; ex_Y = 0;
        step(); step();
        check("rst_bus", {mem_req, mem_we, mem_wstrb, mem_trap, mem_trap_cause}, 0);
        check("rst_bus_data", mem_addr | mem_wdata, 0);
        check("rst_wb", {wb_regD, wb_regWrite, wb_regWriteDouble, wb_icc, wb_icc_write,
                         wb_Y, wb_Y_write}, 0);
        check("rst_result", wb_result, 0);
        reset = 0;

        // Directed cases
        run_op(2'b11, 6'h09, 64'h1004, 0, 64'h0011_2233_8455_6677, 0, 0);
        check("ldsb_const", wb_result, 64'hFFFF_FFFF_FFFF_FF84);
        run_op(2'b11, 6'h02, 64'h1006, 0, 64'h0011_2233_8455_6677, 0, 0);
        check("lduh_const", wb_result, 64'h6677);
        run_op(2'b11, 6'h00, 64'h1004, 0, 64'h0011_2233_8455_6677, 1, 0);
        check("ld_const", wb_result, 64'h0000_0000_8455_6677);
        run_op(2'b11, 6'h03, 64'h1000, 0, 64'h0011_2233_8455_6677, 0, 0);
        check("ldd_const", wb_result, 64'h0011_2233_8455_6677);
        run_op(2'b11, 6'h06, 64'h2002, 64'hABCD, 0, 0, 0);
        run_op(2'b11, 6'h00, 64'h1002, 0, 0, 0, 0);
        run_op(2'b11, 6'h0D, 64'h1000, 0, 0, 0, 0);
        run_op(2'b10, 6'h00, 64'h5, 0, 0, 0, 1);
        run_op(2'b11, 6'h04, 64'h3008, 64'h1234_5678, 0, 3, 0);

        // Reset abandoning an outstanding request
        ex_op = 2'b11; ex_op3 = 6'h00; ex_alures = 64'h4000; mem_ack = 0;
        step();
        check("rw_req", 64'(mem_req), 1);
        reset = 1;
        step();
        reset = 0;
        ex_op = 0; ex_op3 = 0; ex_alures = 0; ex_valD = 0; ex_regD = 0;
        ex_regWrite = 0; ex_regWriteDouble = 0; ex_icc_write = 0; ex_Y_write = 0;
        ex_icc = 0; ex_Y = 0;
        check("rw_req_drop", 64'(mem_req), 0);
        step();
        mem_ack = 1; mem_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
        step();
        mem_ack = 0;
        check("rw_late_ack", {mem_req, wb_regWrite, wb_regWriteDouble, wb_icc_write, wb_Y_write}, 0);
        check("rw_wb_result", wb_result, 0);
        run_op(2'b10, 6'h01, 64'h77, 0, 0, 0, 0);

        // Randomized mix
        for (int t = 0; t < 300; t++) begin
            logic [1:0]  op;
            logic [5:0]  op3;
            logic [63:0] a;
            int n; bit st, sg;
            op  = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 2)) : 2'b11;
            op3 = ($urandom_range(0, 7) == 0) ? 6'($urandom) : good_op3[$urandom_range(0, 9)];
            op_info(op3, n, st, sg);
            a = {$urandom, $urandom};
            if (n != 0 && $urandom_range(0, 3) != 0) a = a & ~(64'(n) - 64'd1);
            run_op(op, op3, a, {$urandom, $urandom}, {$urandom, $urandom},
                   $urandom_range(0, 4), 1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
